// File: rtl/lfsr8_checker.sv
// Receive-side PRBS checker for the 8-bit Fibonacci LFSR pattern generator.
// Self-synchronises on the incoming stream, then flywheels to count bit errors.
module lfsr8_checker #(
   parameter logic [7:0]  TAPS        = 8'hB8,
   parameter int unsigned LOCK_LEN    = 16,
   parameter int unsigned LOSS_LEN    = 4,
   parameter logic [7:0]  PERIOD_MARK = 8'h01
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       BIT_IN,
   input  logic       BIT_EN,
   input  logic       CLR_ERR,
   output logic       LOCKED,
   output logic       ERR_PULSE,
   output logic [7:0] ERR_COUNT,
   output logic       PERIOD_PULSE,
   output logic [7:0] STATE
);

   localparam logic [7:0] LockLen = 8'(LOCK_LEN);
   localparam logic [3:0] LossLen = 4'(LOSS_LEN);
   localparam logic [3:0] FillLen = 4'd8;

   typedef enum logic [0:0] {StHunt, StLocked} state_e;

   state_e     state_q, state_d;
   logic [7:0] s_q, s_d;
   logic [3:0] fill_q, fill_d;
   logic [7:0] match_q, match_d;
   logic [3:0] miss_q, miss_d;

   logic       locked_q, locked_d;
   logic       err_pulse_q, err_pulse_d;
   logic [7:0] err_count_q, err_count_d;
   logic       period_pulse_q, period_pulse_d;

   logic pred;
   logic hit;

   assign pred = ^(s_q & TAPS);
   assign hit  = (BIT_IN == pred);

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= StHunt;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and shift/counter datapath
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      fill_d  = fill_q;
      match_d = match_q;
      miss_d  = miss_q;
      if (BIT_EN) begin
         unique case (state_q)
            StHunt: begin
               s_d = {s_q[6:0], BIT_IN};
               if (fill_q != FillLen) begin
                  fill_d = fill_q + 4'd1;
               end else if (!hit || (s_q == 8'h00)) begin
                  // An all-zero register trivially predicts zeros; never lock on it.
                  match_d = 8'h00;
               end else begin
                  match_d = match_q + 8'd1;
               end
               if ((fill_q == FillLen) && (match_d == LockLen)) begin
                  state_d = StLocked;
                  match_d = 8'h00;
                  miss_d  = 4'd0;
               end
            end
            StLocked: begin
               // Flywheel on our own prediction so one channel error counts once.
               s_d = {s_q[6:0], pred};
               if (hit) begin
                  miss_d = 4'd0;
               end else begin
                  miss_d = miss_q + 4'd1;
                  if (miss_d == LossLen) begin
                     state_d = StHunt;
                     fill_d  = 4'd0;
                     match_d = 8'h00;
                  end
               end
            end
            default: begin
               state_d = StHunt;
            end
         endcase
      end
   end

   // Registered output next values
   always_comb begin
      err_pulse_d    = BIT_EN && (state_q == StLocked) && !hit;
      period_pulse_d = BIT_EN && (state_q == StLocked) && (s_d == PERIOD_MARK);
      locked_d       = (state_d == StLocked);
      err_count_d    = CLR_ERR ? 8'h00 : err_count_q;
      // Clear takes effect before a coincident error is counted.
      if (err_pulse_d && (err_count_d != 8'hFF)) begin
         err_count_d = err_count_d + 8'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         s_q            <= 8'h00;
         fill_q         <= 4'd0;
         match_q        <= 8'h00;
         miss_q         <= 4'd0;
         locked_q       <= 1'b0;
         err_pulse_q    <= 1'b0;
         err_count_q    <= 8'h00;
         period_pulse_q <= 1'b0;
      end else begin
         s_q            <= s_d;
         fill_q         <= fill_d;
         match_q        <= match_d;
         miss_q         <= miss_d;
         locked_q       <= locked_d;
         err_pulse_q    <= err_pulse_d;
         err_count_q    <= err_count_d;
         period_pulse_q <= period_pulse_d;
      end
   end

   assign LOCKED       = locked_q;
   assign ERR_PULSE    = err_pulse_q;
   assign ERR_COUNT    = err_count_q;
   assign PERIOD_PULSE = period_pulse_q;
   assign STATE        = s_q;

endmodule

// File: doc/lfsr8_checker.md
Name: lfsr8_checker

Overview:
- Receive-side companion to the on-chip 8-bit LFSR test-pattern generator.
- Consumes the serial bitstream coming back out of the SISO shift-register chain.
- Self-synchronises to the PRBS, then flywheels on its own prediction: counts bit errors, flags loss of lock and marks sequence period boundaries.
- Sits on the CLK_OUT domain, downstream of the SISO output.

Parameters:
TAPS, 8'hB8, Fibonacci feedback mask. Feedback = XOR of state bits selected by TAPS (x^8+x^6+x^5+x^4+1, period 255); must match the generator.
LOCK_LEN, 16, consecutive correct predictions required in HUNT before declaring lock (1..255).
LOSS_LEN, 4, consecutive mispredictions in LOCKED that force return to HUNT (1..15).
PERIOD_MARK, 8'h01, state value at which PERIOD_PULSE fires.

Ports:
CLK  in  1  clock; all logic on rising edge
RESET  in  1  synchronous reset, active-high
BIT_IN  in  1  received serial bit
BIT_EN  in  1  BIT_IN valid this cycle; no state changes when low
CLR_ERR  in  1  synchronous clear of ERR_COUNT
LOCKED  out  1  checker synchronised
ERR_PULSE  out  1  one-cycle strobe per mispredicted bit while LOCKED
ERR_COUNT  out  8  saturating error count
PERIOD_PULSE  out  1  one-cycle strobe when the checker state enters PERIOD_MARK while LOCKED
STATE  out  8  current checker shift state, for debug and Gray/PULSES routing

Behaviour:
- Reset values: S=8'h00, fill counter 0, match counter 0, miss counter 0, FSM=HUNT. Outputs: LOCKED=0, ERR_PULSE=0, ERR_COUNT=0, PERIOD_PULSE=0, STATE=0.
- Reset has priority over everything, including mid-lock: the next cycle is in HUNT with all counters cleared.
- Prediction: P = ^(S & TAPS). Match means BIT_IN==P.
- All outputs are registered. Effects appear the cycle after the BIT_EN sample.
- FSM has two states, HUNT and LOCKED. Only cycles with BIT_EN=1 advance anything.
- HUNT:
  - S <= {S[6:0], BIT_IN}.
  - Fill counter saturates at 8. Matches are not evaluated until 8 bits have been loaded.
  - After fill, a match increments the match counter; a mismatch clears it.
  - The match counter is also cleared whenever S==0 (guards lock onto stuck-at-0).
  - When the match counter reaches LOCK_LEN, go to LOCKED. LOCKED=1 on the following cycle; the miss counter clears.
  - No ERR_PULSE and no ERR_COUNT changes in HUNT.
- LOCKED:
  - S <= {S[6:0], P} (flywheel), so a single channel error counts exactly once.
  - Mismatch: ERR_PULSE=1 for one cycle and ERR_COUNT increments (saturating at 8'hFF, no wrap). The miss counter increments.
  - Match: the miss counter clears.
  - When the miss counter reaches LOSS_LEN, go to HUNT. LOCKED drops next cycle, fill counter resets to 0, and S reloads from the incoming stream.
  - The LOSS_LEN-th mismatch is still counted.
- PERIOD_PULSE=1 for one cycle when the new S equals PERIOD_MARK while LOCKED. This occurs every 255 valid bits.
- CLR_ERR:
  - Zeroes ERR_COUNT the next cycle.
  - If CLR_ERR coincides with an error, the result is ERR_COUNT=1 (clear then count). ERR_PULSE is unaffected.
- BIT_EN=0: all state holds, and all pulse outputs are 0 that cycle.
- STATE mirrors S (registered).

Test Plan:
- Lock acquisition: reset, then feed the generator stream from seed 8'h01 with BIT_EN=1 every cycle. LOCKED must rise the cycle after the 24th valid bit (8 fill + 16 matches); ERR_COUNT=0.
- Single error: after lock, invert one bit. Exactly one ERR_PULSE, ERR_COUNT=1, LOCKED stays 1, and the next 300 bits give no further errors.
- Loss of lock:
  - After lock, drive BIT_IN opposite to the prediction for 4 consecutive valid bits.
  - Required: 4 ERR_PULSEs, ERR_COUNT=4, LOCKED=0 on the cycle after the 4th.
  - Then re-lock 24 valid bits later.
- Stuck-at-0: hold BIT_IN=0 for 100 valid bits after reset. LOCKED must stay 0 and STATE stays 8'h00.
- Period and gaps:
  - Locked stream with BIT_EN toggling 1/0.
  - Required: PERIOD_PULSE spaced exactly 255 valid bits apart, never asserted on BIT_EN=0 cycles, STATE held across gaps.
- Saturation, clear and reset:
  - Force 300 errors with lock maintained (isolated errors): ERR_COUNT=8'hFF, no wrap.
  - CLR_ERR coinciding with an error: ERR_COUNT=1.
  - RESET while locked: LOCKED=0 and ERR_COUNT=0 the next cycle.
